// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Types and constants shared by the SPI controller and the
//                SPI peripheral side. This covers the controller state
//                encoding, the SPI mode (CPOL/CPHA), the transfer length and
//                a helper that derives the idle SCK level from the mode.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // no transfer, CSN high
    ST_SHIFT = 3'd1,  // clocking a byte out and in
    ST_WAIT  = 3'd2,  // byte done, CSN held low for a follow-on byte
    ST_HOLD  = 3'd3,  // last byte done, CSN low for one half period
    ST_GAP   = 3'd4   // CSN high for one half period before IDLE
  } spi_state_e;

  // SPI mode as {CPOL, CPHA}; mode 0 -> SCK idles low, sample on leading edge
  localparam logic [1:0] SPI_MODE = 2'b00;

  // Bits per transfer, MSB first
  localparam int SPI_BITS = 8;

  // Idle level of SCK for a given mode (the CPOL bit)
  function automatic logic sck_idle_level(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ctrl
//  Description : Single-chip-select SPI controller, mode 0, 8-bit MSB-first
//                transfers with a ready/valid byte interface. Consecutive
//                bytes without tx_last keep CSN asserted. The half-period
//                divider is inline.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   system clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    tx_data   in   [7:0] byte to send, MSB first
//    tx_last   in   release CSN after this byte
//    tx_valid  in   tx_data/tx_last present
//    tx_ready  out  byte accepted when tx_valid & tx_ready
//    rx_data   out  [7:0] last byte sampled from spi_sdi
//    rx_valid  out  one-cycle strobe, rx_data updated
//    busy      out  controller not in IDLE
//    spi_sck   out  serial clock
//    spi_csn   out  chip select, active low
//    spi_sdo   out  controller data out
//    spi_sdi   in   peripheral data in
// ============================================================================
module spi_ctrl
  import spi_pkg::*;
#(
  parameter int TICKS_PER_HALF_SCK = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  localparam int                CNT_W      = $clog2(TICKS_PER_HALF_SCK + 1);
  // Counter runs H-1 .. 0, so every phase lasts exactly H cycles
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(TICKS_PER_HALF_SCK - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic              SCK_IDLE   = sck_idle_level(SPI_MODE);
  localparam logic [2:0]        LAST_BIT   = 3'(SPI_BITS - 1);

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;       // completed trailing edges
  logic [7:0]       tx_sh_q, tx_sh_d;   // bit 7 drives spi_sdo
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             last_q, last_d;     // tx_last captured at accept
  logic             sck_q, sck_d;
  logic             csn_q, csn_d;
  logic             ready_q, ready_d;

  logic             w_accept;
  logic             w_tick;
  logic             w_lead;             // next SCK toggle is the sampling edge

  assign w_accept = tx_valid && ready_q;
  assign w_tick   = (cnt_q == '0);
  assign w_lead   = (sck_q == SCK_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    sck_d      = sck_q;
    csn_d      = csn_q;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (w_accept) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          tx_sh_d = tx_data;
          last_d  = tx_last;
          csn_d   = 1'b0;
          sck_d   = SCK_IDLE;
        end
      end

      ST_SHIFT: begin
        if (w_tick) begin
          cnt_d = CNT_RELOAD;
          sck_d = ~sck_q;
          if (w_lead) begin
            rx_sh_d = {rx_sh_q[6:0], spi_sdi};
          end else if (bit_q == LAST_BIT) begin
            // Final trailing edge: sdo keeps the last bit, byte is complete
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? ST_HOLD : ST_WAIT;
          end else begin
            bit_d   = 3'(bit_q + 3'd1);
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (w_tick) begin
          csn_d   = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_GAP: begin
        if (w_tick) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        csn_d   = 1'b1;
        sck_d   = SCK_IDLE;
      end
    endcase

    // Registered so that tx_ready stays low throughout reset
    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      sck_q      <= SCK_IDLE;
      csn_q      <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_ready = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign spi_sck  = sck_q;
  assign spi_csn  = csn_q;
  assign spi_sdo  = tx_sh_q[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ctrl
//  Description : Directed bench for spi_ctrl. One instance uses H=2 and a
//                second uses H=1. A mux selects which instance is driven and
//                observed. The bench contains an SPI peripheral model and an
//                rx scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       sel;          // 0: H=2 instance, 1: H=1 instance
  logic [1:0] sdi_mode;     // 0: loop sdo, 1: tied high, 2: peripheral model
  logic [7:0] p_sh = 8'h00;
  logic       spi_sdi;

  logic       tx_valid0, tx_ready0, rx_valid0, busy0, sck0, csn0, sdo0;
  logic       tx_valid1, tx_ready1, rx_valid1, busy1, sck1, csn1, sdo1;
  logic [7:0] rx_data0, rx_data1;
  logic       tx_ready_m, rx_valid_m, busy_m, sck_m, csn_m, sdo_m;
  logic [7:0] rx_data_m;

  assign tx_valid0  = tx_valid & ~sel;
  assign tx_valid1  = tx_valid &  sel;
  assign tx_ready_m = sel ? tx_ready1 : tx_ready0;
  assign rx_valid_m = sel ? rx_valid1 : rx_valid0;
  assign rx_data_m  = sel ? rx_data1  : rx_data0;
  assign busy_m     = sel ? busy1     : busy0;
  assign sck_m      = sel ? sck1      : sck0;
  assign csn_m      = sel ? csn1      : csn0;
  assign sdo_m      = sel ? sdo1      : sdo0;
  assign spi_sdi    = (sdi_mode == 2'd0) ? sdo_m :
                      (sdi_mode == 2'd1) ? 1'b1  : p_sh[7];

  spi_ctrl #(.TICKS_PER_HALF_SCK(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .busy(busy0), .spi_sck(sck0), .spi_csn(csn0),
    .spi_sdo(sdo0), .spi_sdi(spi_sdi)
  );

  spi_ctrl #(.TICKS_PER_HALF_SCK(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .busy(busy1), .spi_sck(sck1), .spi_csn(csn1),
    .spi_sdo(sdo1), .spi_sdi(spi_sdi)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observation state filled by the monitor
  int         rises = 0, rxv_cnt = 0, rxv_t = 0, csn_rises = 0, csn_hi_t = 0;
  int         rise_t[$], fall_t[$];
  logic [7:0] obs_q[$], exp_q[$], resp_q[$], p_got[$];

  int n_vec = 0;
  int n_err = 0;

  // Monitor plus mode-0 peripheral: loads its byte while CSN is low,
  // samples sdo on SCK rise and shifts out on SCK fall.
  initial begin : mon
    logic       sck_p, csn_p, p_loaded;
    logic [7:0] p_rx;
    int         p_cnt;
    sck_p = 1'b0; csn_p = 1'b1; p_loaded = 1'b0; p_rx = 8'h00; p_cnt = 0;
    forever begin
      @(negedge clk);
      if (sck_m && !sck_p) begin rises++; rise_t.push_back(cyc); end
      if (!sck_m && sck_p) fall_t.push_back(cyc);
      if (csn_m && !csn_p) begin csn_rises++; csn_hi_t = cyc; end
      if (rx_valid_m) begin rxv_cnt++; rxv_t = cyc; obs_q.push_back(rx_data_m); end
      if (csn_m) begin
        p_cnt = 0; p_loaded = 1'b0;
      end else begin
        if (sck_m && !sck_p) p_rx = {p_rx[6:0], sdo_m};
        if (!sck_m && sck_p) begin
          p_cnt++;
          if (p_cnt == 8) begin
            p_got.push_back(p_rx); p_cnt = 0; p_loaded = 1'b0;
          end else begin
            p_sh = {p_sh[6:0], 1'b0};
          end
        end
        if (!p_loaded) begin
          if (resp_q.size() > 0) p_sh = resp_q.pop_front();
          else                   p_sh = 8'h00;
          p_loaded = 1'b1;
        end
      end
      sck_p = sck_m; csn_p = csn_m;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Present a byte, wait (bounded) for the handshake, return accept cycle T.
  // Called just after a falling edge; returns at cycle T+1.
  task automatic send(input logic [7:0] d, input logic last, input bit keep, output int t);
    int n;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready_m && n < 300) begin @(negedge clk); n++; end
    chk("accept_bound", 32'(n < 300), 32'd1);
    @(negedge clk);
    t = cyc - 1;
    chk("csn_low_T+1", csn_m, 1'b0);
    chk("sdo_msb_T+1", sdo_m, d[7]);
    if (keep) begin tx_data = 8'hFF; tx_last = 1'b0; end
    else        tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t_rdy);
    int n;
    n = 0;
    while (!(tx_ready_m && !busy_m) && n < 500) begin @(negedge clk); n++; end
    t_rdy = cyc;
    chk("idle_bound", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_rxv();
    int n;
    n = 0;
    while (!rx_valid_m && n < 300) begin @(negedge clk); n++; end
    chk("rxv_bound", 32'(n < 300), 32'd1);
  endtask

  // Scoreboard: pair each observed rx byte with the oldest expected one
  task automatic drain();
    logic [7:0] g, w;
    while (obs_q.size() > 0) begin
      g = obs_q.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front();
      else                  w = 8'hxx;
      chk("rx_data", g, w);
    end
  endtask

  task automatic chk_got(input string tag, input logic [7:0] want);
    logic [7:0] b;
    if (p_got.size() > 0) b = p_got.pop_front();
    else                  b = 8'hxx;
    chk(tag, b, want);
  endtask

  task automatic check_sck(input int t, input int h);
    chk("sck_rise_count", rise_t.size(), 8);
    chk("sck_fall_count", fall_t.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < rise_t.size()) chk($sformatf("sck_rise%0d", k), rise_t[k], t + 1 + h*(2*k+1));
      if (k < fall_t.size()) chk($sformatf("sck_fall%0d", k), fall_t[k], t + 1 + h*(2*k+2));
    end
  endtask

  initial begin : stim
    int t, t2, tr, r0, c0, v0, n, bad, cnt;
    logic prev;

    // Reset values
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    sel = 1'b0; sdi_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_csn", csn_m, 1'b1);
    chk("rst_sck", sck_m, 1'b0);
    chk("rst_sdo", sdo_m, 1'b0);
    chk("rst_ready", tx_ready_m, 1'b0);
    chk("rst_rxv", rx_valid_m, 1'b0);
    chk("rst_rxdata", rx_data_m, 8'h00);
    chk("rst_busy", busy_m, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready_m, 1'b1);

    // 0xA5, tx_last=1, loopback
    rise_t.delete(); fall_t.delete(); p_got.delete();
    c0 = csn_rises;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0, t);
    wait_idle(tr);
    drain();
    check_sck(t, 2);
    chk("A_rxv_time", rxv_t, t + 33);
    chk("A_csn_high_time", csn_hi_t, t + 35);
    chk("A_ready_time", tr, t + 37);
    chk("A_csn_rises", csn_rises - c0, 1);
    chk_got("A_periph_rx", 8'hA5);

    // 0x3C then 0xC3 back to back, peripheral returns 0x81, 0x18
    sdi_mode = 2'd2; p_got.delete();
    resp_q.push_back(8'h81); resp_q.push_back(8'h18);
    r0 = rises; c0 = csn_rises;
    exp_q.push_back(8'h81);
    send(8'h3C, 1'b0, 1'b0, t);
    exp_q.push_back(8'h18);
    send(8'hC3, 1'b1, 1'b0, t2);
    wait_idle(tr);
    drain();
    chk("B_rises", rises - r0, 16);
    chk("B_csn_rises", csn_rises - c0, 1);
    chk_got("B_periph_rx0", 8'h3C);
    chk_got("B_periph_rx1", 8'hC3);

    // tx_valid held with 0xFF during SHIFT
    sdi_mode = 2'd0; p_got.delete();
    r0 = rises; v0 = rxv_cnt;
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, 1'b1, t);
    bad = 0; n = 0;
    while (!rx_valid_m && n < 300) begin
      if (tx_ready_m) bad++;
      @(negedge clk); n++;
    end
    tx_valid = 1'b0;
    chk("C_ready_low_cycles", bad, 0);
    wait_idle(tr);
    drain();
    chk("C_rises", rises - r0, 8);
    chk("C_rxv_count", rxv_cnt - v0, 1);
    chk_got("C_periph_rx", 8'h96);

    // Reset at the 4th SCK rise
    exp_q.push_back(8'hE7);
    send(8'hE7, 1'b1, 1'b0, t);
    cnt = 0; n = 0; prev = sck_m;
    while (cnt < 4 && n < 300) begin
      @(negedge clk); n++;
      if (sck_m && !prev) cnt++;
      prev = sck_m;
    end
    chk("D_rise4_bound", 32'(cnt == 4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("D_rst_csn", csn_m, 1'b1);
    chk("D_rst_sck", sck_m, 1'b0);
    chk("D_rst_sdo", sdo_m, 1'b0);
    chk("D_rst_busy", busy_m, 1'b0);
    chk("D_rst_ready", tx_ready_m, 1'b0);
    exp_q.delete();
    v0 = rxv_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("D_ready_after_rst", tx_ready_m, 1'b1);
    chk("D_no_rxv", rxv_cnt - v0, 0);
    chk("D_no_rx_byte", obs_q.size(), 0);
    p_got.delete();
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0, t);
    wait_idle(tr);
    drain();
    chk_got("D_periph_rx", 8'h5A);

    // 100 cycles parked in WAIT, then 0x7E
    p_got.delete(); c0 = csn_rises;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0, 1'b0, t);
    wait_rxv();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (csn_m !== 1'b0 || sck_m !== 1'b0 || tx_ready_m !== 1'b1) bad++;
    end
    chk("E_wait_bad_cycles", bad, 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, 1'b0, t);
    wait_idle(tr);
    drain();
    chk("E_csn_rises", csn_rises - c0, 1);
    chk_got("E_periph_rx0", 8'h3C);
    chk_got("E_periph_rx1", 8'h7E);

    // H=1 instance: 0x00 with sdi tied high
    sel = 1'b1; sdi_mode = 2'd1;
    @(negedge clk);
    rise_t.delete(); fall_t.delete(); p_got.delete();
    exp_q.push_back(8'hFF);
    send(8'h00, 1'b1, 1'b0, t);
    wait_idle(tr);
    drain();
    check_sck(t, 1);
    if (rise_t.size() >= 2) chk("F_sck_period", rise_t[1] - rise_t[0], 2);
    chk("F_rxv_time", rxv_t, t + 17);
    chk("F_csn_high_time", csn_hi_t, t + 18);
    chk("F_ready_time", tr, t + 19);
    chk_got("F_periph_rx", 8'h00);

    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
